// File: rtl/wram_pkg.sv
// Shared definitions for the WRAM arbiter slice.
//   WRAM_AW / WRAM_DW : default address / data widths of the WRAM wrapper
//   OWN_CPU / OWN_DMA : encoding of the requester that owns an access
//   arb_state_e       : arbiter FSM states (last bank owner)
package wram_pkg;

    localparam int WRAM_AW = 16;
    localparam int WRAM_DW = 8;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CPU  = 2'd1,
        DMA  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/wram_rd_tracker.sv
// Read-return tracker for the WRAM arbiter.
// Remembers whether a read was issued last cycle and by whom, then steers the
// RAM's 1-cycle-late read data and an rvalid pulse back to that requester.
// Each requester's rdata holds its last returned value outside rvalid.
// Ports:
//   clka, rsta             clock, async active-low reset
//   rd_issue, rd_owner_in  a read is issued to the RAM this cycle, and its owner
//   ram_douta              RAM read data (valid the cycle after issue)
//   cpu_rvalid/cpu_rdata   CPU read return
//   dma_rvalid/dma_rdata   DMA read return
module wram_rd_tracker
    import wram_pkg::*;
#(
    parameter int DW = WRAM_DW
) (
    input  logic          clka,
    input  logic          rsta,
    input  logic          rd_issue,
    input  logic          rd_owner_in,
    input  logic [DW-1:0] ram_douta,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata
);

    logic          rd_pend;
    logic          rd_owner;
    logic [DW-1:0] cpu_hold;
    logic [DW-1:0] dma_hold;

    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            rd_pend  <= 1'b0;
            rd_owner <= OWN_CPU;
            cpu_hold <= '0;
            dma_hold <= '0;
        end else begin
            rd_pend <= rd_issue;
            if (rd_issue) begin
                rd_owner <= rd_owner_in;
            end
            if (cpu_rvalid) begin
                cpu_hold <= ram_douta;
            end
            if (dma_rvalid) begin
                dma_hold <= ram_douta;
            end
        end
    end

    assign cpu_rvalid = rd_pend && (rd_owner == OWN_CPU);
    assign dma_rvalid = rd_pend && (rd_owner == OWN_DMA);

    // RAM data is only valid in the return cycle, so pass it straight through
    // then and fall back to the captured copy afterwards.
    assign cpu_rdata = cpu_rvalid ? ram_douta : cpu_hold;
    assign dma_rdata = dma_rvalid ? ram_douta : dma_hold;

endmodule

// File: rtl/wram_arbiter.sv
// CPU/DMA arbiter for one single-ported WRAM bank.
// Fixed priority to the CPU; a pending DMA request denied MAX_WAIT cycles in a
// row is granted on the next cycle. Reads return one cycle after issue and are
// steered back to the requester that issued them (wram_rd_tracker).
// Optional build macro WRAM_ARB_LOCK_EN adds dma_lock: while the DMA owns the
// bank and holds dma_lock, the CPU is never granted (atomic DMA bursts).
// Ports:
//   clka, rsta                                  clock, async active-low reset
//   cpu_req/we/addr/wdata, cpu_gnt/rvalid/rdata CPU side
//   dma_req/we/addr/wdata, dma_gnt/rvalid/rdata DMA side
//   dma_lock                                    (WRAM_ARB_LOCK_EN only)
//   ram_ena/wea/addra/dina, ram_douta           WRAM wrapper port A
//
// state | meaning
// IDLE  | no access granted since reset
// CPU   | last granted access belonged to the CPU
// DMA   | last granted access belonged to the DMA (lock applies here)
module wram_arbiter
    import wram_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int AW       = WRAM_AW,
    parameter int DW       = WRAM_DW
) (
    input  logic          clka,
    input  logic          rsta,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,
`ifdef WRAM_ARB_LOCK_EN
    input  logic          dma_lock,
`endif
    output logic          ram_ena,
    output logic          ram_wea,
    output logic [AW-1:0] ram_addra,
    output logic [DW-1:0] ram_dina,
    input  logic [DW-1:0] ram_douta
);

    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    arb_state_e  state_q;
    arb_state_e  state_d;
    logic [3:0]  wait_cnt;
    logic        lock_blk;
    logic        cpu_ok;
    logic        dma_win;
    logic        cpu_win;

`ifdef WRAM_ARB_LOCK_EN
    assign lock_blk = (state_q == DMA) && dma_lock;
`else
    // Without the lock the owner state is informational only.
    logic state_unused;
    assign state_unused = ^state_q;
    assign lock_blk     = 1'b0;
`endif

    assign cpu_ok  = cpu_req && !lock_blk;
    assign dma_win = dma_req && (!cpu_ok || (wait_cnt == MAX_W));
    assign cpu_win = cpu_ok && !dma_win;

    // Nothing reaches the RAM while reset is asserted, even with requests up.
    assign cpu_gnt = cpu_win && rsta;
    assign dma_gnt = dma_win && rsta;
    assign ram_ena = cpu_gnt || dma_gnt;

    assign ram_wea   = dma_win ? dma_we    : cpu_we;
    assign ram_addra = dma_win ? dma_addr  : cpu_addr;
    assign ram_dina  = dma_win ? dma_wdata : cpu_wdata;

    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            wait_cnt <= 4'd0;
        end else if (dma_req && !dma_gnt) begin
            wait_cnt <= (wait_cnt == MAX_W) ? MAX_W : wait_cnt + 4'd1;
        end else begin
            wait_cnt <= 4'd0;
        end
    end

    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (dma_gnt) begin
            state_d = DMA;
        end else if (cpu_gnt) begin
            state_d = CPU;
        end
    end

    wram_rd_tracker #(
        .DW (DW)
    ) u_rd_tracker (
        .clka        (clka),
        .rsta        (rsta),
        .rd_issue    (ram_ena && !ram_wea),
        .rd_owner_in (dma_win ? OWN_DMA : OWN_CPU),
        .ram_douta   (ram_douta),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata),
        .dma_rvalid  (dma_rvalid),
        .dma_rdata   (dma_rdata)
    );

endmodule

// File: tb/tb_wram_arbiter.sv
// Bench for wram_arbiter: directed scenarios followed by random traffic, all
// checked every cycle against a transaction-level reference model (denial
// counter, last-owner flag, shadow memory, one-deep read-return slot).
// Define WRAM_ARB_LOCK_EN to also exercise the dma_lock path.
module tb_wram_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clka = 1'b0;
    logic        rsta;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [15:0] cpu_addr, dma_addr;
    logic [7:0]  cpu_wdata, dma_wdata;
    logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
    logic [7:0]  cpu_rdata, dma_rdata;
    logic        ram_ena, ram_wea;
    logic [15:0] ram_addra;
    logic [7:0]  ram_dina, ram_douta;
`ifdef WRAM_ARB_LOCK_EN
    logic        dma_lock;
`endif

    always #5 clka = ~clka;

    wram_arbiter #(.MAX_WAIT(MAX_WAIT), .AW(16), .DW(8)) dut (
        .clka       (clka),
        .rsta       (rsta),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_gnt    (dma_gnt),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
`ifdef WRAM_ARB_LOCK_EN
        .dma_lock   (dma_lock),
`endif
        .ram_ena    (ram_ena),
        .ram_wea    (ram_wea),
        .ram_addra  (ram_addra),
        .ram_dina   (ram_dina),
        .ram_douta  (ram_douta)
    );

    // WRAM stand-in: 64-byte window at 0xC000, synchronous read.
    logic       init_ram;
    logic [7:0] mem [0:63];
    always @(posedge clka) begin
        if (init_ram) begin
            for (int i = 0; i < 64; i++) mem[i] <= 8'(i * 7 + 60);
        end else if (ram_ena) begin
            if (ram_wea) mem[ram_addra[5:0]] <= ram_dina;
            else         ram_douta <= mem[ram_addra[5:0]];
        end
    end

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int         denied;
    bit         last_dma;
    bit         pend_v, pend_dma;
    logic [7:0] pend_data, cpu_last, dma_last;
    logic [7:0] shadow [0:63];
    int         cpu_gnt_obs, dma_gnt_obs;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        denied   = 0;
        last_dma = 0;
        pend_v   = 0;
        pend_dma = 0;
        cpu_last = 8'h00;
        dma_last = 8'h00;
    endtask

    // One clock of the bench: inputs were driven at posedge+1; check at the
    // falling edge, advance the model at the rising edge.
    task automatic cyc();
        bit          blk, dwin, cwin, wr;
        logic [15:0] a;
        logic [7:0]  d;
        @(negedge clka);
        blk = 0;
`ifdef WRAM_ARB_LOCK_EN
        blk = last_dma && dma_lock;
`endif
        dwin = dma_req && (!(cpu_req && !blk) || denied >= MAX_WAIT);
        cwin = cpu_req && !blk && !dwin;
        a  = dwin ? dma_addr  : cpu_addr;
        d  = dwin ? dma_wdata : cpu_wdata;
        wr = dwin ? dma_we    : cpu_we;
        chk("cpu_gnt", cpu_gnt, cwin);
        chk("dma_gnt", dma_gnt, dwin);
        chk("ram_ena", ram_ena, dwin || cwin);
        if (dwin || cwin) begin
            chk("ram_addra", ram_addra, a);
            chk("ram_wea", ram_wea, wr);
            if (wr) chk("ram_dina", ram_dina, d);
        end
        chk("cpu_rvalid", cpu_rvalid, pend_v && !pend_dma);
        chk("dma_rvalid", dma_rvalid, pend_v && pend_dma);
        chk("cpu_rdata", cpu_rdata, (pend_v && !pend_dma) ? pend_data : cpu_last);
        chk("dma_rdata", dma_rdata, (pend_v && pend_dma) ? pend_data : dma_last);
        chk("wait_cnt_bound", dut.wait_cnt <= 4'(MAX_WAIT), 1);
        if (cpu_gnt) cpu_gnt_obs++;
        if (dma_gnt) dma_gnt_obs++;
        @(posedge clka);
        if (pend_v) begin
            if (pend_dma) dma_last = pend_data;
            else          cpu_last = pend_data;
        end
        pend_v   = (dwin || cwin) && !wr;
        pend_dma = dwin;
        if (pend_v) pend_data = shadow[a[5:0]];
        if ((dwin || cwin) && wr) shadow[a[5:0]] = d;
        if (dma_req && !dwin) denied = (denied >= MAX_WAIT) ? MAX_WAIT : denied + 1;
        else                  denied = 0;
        if (dwin)      last_dma = 1;
        else if (cwin) last_dma = 0;
        #1;
    endtask

    task automatic idle_bus();
        cpu_req = 0; dma_req = 0;
`ifdef WRAM_ARB_LOCK_EN
        dma_lock = 0;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rsta = 0; init_ram = 1;
        cpu_we = 0; cpu_addr = 16'hC000; cpu_wdata = 0;
        dma_we = 0; dma_addr = 16'hC000; dma_wdata = 0;
        idle_bus();
        for (int i = 0; i < 64; i++) shadow[i] = 8'(i * 7 + 60);
        model_reset();
        @(posedge clka); @(posedge clka); #1;
        init_ram = 0;
        @(negedge clka);
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_ram_ena", ram_ena, 0);
        chk("rst_cpu_rvalid", cpu_rvalid, 0);
        chk("rst_dma_rvalid", dma_rvalid, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_dma_rdata", dma_rdata, 0);
        rsta = 1;
        @(posedge clka); #1;
        cyc();

        // CPU write 0xA5 to 0xC010, then read it back
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'hC010; cpu_wdata = 8'hA5; cyc();
        cpu_we = 0; cyc();
        cpu_req = 0; cyc();
        chk("cpu_readback", cpu_rdata, 8'hA5);

        // Contention: both held for 15 cycles, DMA must get every 5th slot
        cpu_gnt_obs = 0; dma_gnt_obs = 0;
        cpu_req = 1; dma_req = 1; dma_we = 0; cpu_we = 1;
        for (int i = 0; i < 15; i++) begin
            cpu_addr  = 16'hC008 + 16'(i % 4);
            cpu_wdata = 8'($urandom);
            dma_addr  = 16'hC000 + 16'(i);
            cyc();
        end
        chk("contention_dma_slots", dma_gnt_obs, 3);
        chk("contention_cpu_slots", cpu_gnt_obs, 12);
        idle_bus(); cyc();

        // DMA back-to-back reads 0xC000..0xC003
        dma_gnt_obs = 0;
        dma_req = 1; dma_we = 0;
        for (int i = 0; i < 4; i++) begin
            dma_addr = 16'hC000 + 16'(i);
            cyc();
        end
        dma_req = 0; cyc();
        chk("b2b_dma_grants", dma_gnt_obs, 4);
        chk("b2b_last_data", dma_rdata, shadow[3]);

        // Interleaved: CPU read then DMA read on consecutive cycles
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'hC020; cyc();
        cpu_req = 0; dma_req = 1; dma_we = 0; dma_addr = 16'hC021; cyc();
        dma_req = 0; cyc();
        cyc();
        chk("interleave_cpu", cpu_rdata, shadow[6'h20]);
        chk("interleave_dma", dma_rdata, shadow[6'h21]);

        // Reset asserted while a CPU read is outstanding
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'hC005; cyc();
        dma_req = 1;
        rsta = 0;
        #1;
        chk("midrst_cpu_rvalid", cpu_rvalid, 0);
        chk("midrst_dma_rvalid", dma_rvalid, 0);
        chk("midrst_cpu_gnt", cpu_gnt, 0);
        chk("midrst_dma_gnt", dma_gnt, 0);
        chk("midrst_ram_ena", ram_ena, 0);
        chk("midrst_cpu_rdata", cpu_rdata, 0);
        model_reset();
        @(posedge clka); #1;
        idle_bus();
        rsta = 1;
        cyc();
        cyc();

`ifdef WRAM_ARB_LOCK_EN
        // Locked DMA burst: 3 writes with gaps while the CPU keeps asking
        dma_req = 1; dma_we = 1; dma_lock = 1; dma_addr = 16'hC030; dma_wdata = 8'h11;
        cyc();
        cpu_gnt_obs = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'hC031;
        dma_req = 0; cyc();
        dma_req = 1; dma_addr = 16'hC032; dma_wdata = 8'h22; cyc();
        dma_req = 0; cyc();
        dma_req = 1; dma_addr = 16'hC033; dma_wdata = 8'h33; cyc();
        chk("lock_cpu_held_off", cpu_gnt_obs, 0);
        dma_req = 0; dma_lock = 0; cyc();
        chk("lock_release_gnt", cpu_gnt_obs, 1);
        idle_bus(); cyc();
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cpu_req   = ($urandom_range(0, 3) != 0);
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = 16'hC000 + 16'($urandom_range(0, 63));
            cpu_wdata = 8'($urandom);
            dma_req   = 1'($urandom_range(0, 1));
            dma_we    = 1'($urandom_range(0, 1));
            dma_addr  = 16'hC000 + 16'($urandom_range(0, 63));
            dma_wdata = 8'($urandom);
`ifdef WRAM_ARB_LOCK_EN
            dma_lock  = ($urandom_range(0, 3) == 0);
`endif
            cyc();
        end
        idle_bus(); cyc(); cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wram_arbiter.md
Name: wram_arbiter

Overview:
- Two-requester arbiter sharing one single-ported WRAM bank (the work-RAM wrapper instance) between the CPU (port 0) and the DMA engine (port 1).
- Fixed priority to CPU, with a starvation guard that forces a DMA grant after MAX_WAIT consecutive denied cycles.
- Tracks the 1-cycle synchronous read latency of the RAM and steers read data and rvalid back to the requester that issued the read.
- Sits between the CPU/DMA bus fabric and the WRAM wrapper; passes the full 16-bit address through, and the wrapper does window decode.

Parameters:
- MAX_WAIT, 4: consecutive cycles a pending DMA request may be denied before a forced DMA grant; legal range 1..15.
- AW, 16: address width.
- DW, 8: data width.

Ports:
- clka  in  1  clock; all state on rising edge.
- rsta  in  1  asynchronous reset, active-low.
- cpu_req  in  1  CPU access request; held until granted.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_gnt  out  1  access issued to RAM this cycle.
- cpu_rvalid  out  1  CPU read data valid.
- cpu_rdata  out  DW  CPU read data.
- dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_rvalid, dma_rdata: same as the cpu_* ports, for DMA.
- dma_lock  in  1  present only with WRAM_ARB_LOCK_EN; see Optional Feature.
- ram_ena  out  1  to WRAM ena.
- ram_wea  out  1  to WRAM wea.
- ram_addra  out  AW  to WRAM addra.
- ram_dina  out  DW  to WRAM dina.
- ram_douta  in  DW  from WRAM douta; valid 1 cycle after a read issue.

Behaviour:
- Reset (rsta low, async):
  - gnt, rvalid and ram_ena = 0; rdata = 0; wait_cnt = 0; rd_pend = 0; state = IDLE.
  - ram_ena is forced 0 while rsta is low.
- Arbitration (combinational, same cycle):
  - Winner = DMA if dma_req && (!cpu_req || wait_cnt == MAX_WAIT); else CPU if cpu_req; else none.
  - Winner's gnt = 1. ram_ena = 1. ram_wea/addra/dina are muxed from the winner.
  - With no winner: ram_ena = 0, and the other ram_* outputs hold the CPU fields (don't-care).
- Handshake:
  - A request is consumed on the cycle gnt = 1.
  - The requester may change its fields or raise a new request the next cycle, giving back-to-back one access per cycle.
  - Dropping req without a grant is legal: nothing is issued.
- wait_cnt (saturates at MAX_WAIT):
  - Increments when dma_req && !dma_gnt.
  - Clears on dma_gnt or when !dma_req.
- Read return:
  - On a granted read, register rd_pend = 1 and rd_owner = winner.
  - Next cycle: the owner's rvalid = 1 and its rdata = ram_douta.
  - Outside rvalid, rdata holds its last value.
  - Writes produce no rvalid.
  - Reads and writes pipeline freely; a new grant in the rvalid cycle is legal.
- Simultaneous requests:
  - CPU wins, except on the forced cycle, where DMA wins and CPU sees gnt = 0 and retries.
- Reset mid-read: any pending rvalid is dropped.
- FSM states IDLE/CPU/DMA record the last owner and are used by the lock feature; without the feature they are informational only.

Optional Feature:
- Macro: WRAM_ARB_LOCK_EN.
- With the macro defined:
  - dma_lock input exists.
  - While state = DMA and dma_lock = 1, the CPU is never granted, even if dma_req drops, so that DMA bursts are atomic.
  - Lock releases the cycle after dma_lock is deasserted.
- Without the macro:
  - No dma_lock port.
  - Arbitration is purely as above.

Decomposition:
- Shared package wram_pkg holds:
  - WRAM_AW = 16, WRAM_DW = 8.
  - Owner encoding: OWN_CPU = 0, OWN_DMA = 1.
  - FSM state enum: IDLE, CPU, DMA.
- One sub-module, wram_rd_tracker: the rd_pend/rd_owner register and the rvalid/rdata steering.

Test Plan:
- Reset: assert rsta = 0 mid-read → all gnt/rvalid = 0, ram_ena = 0; after release, no stray rvalid.
- CPU write then read: write 0xA5 to 0xC010, then read 0xC010 → cpu_gnt in both cycles; cpu_rvalid = 1 one cycle after the read grant with cpu_rdata = 0xA5.
- Contention: cpu_req and dma_req held continuously (MAX_WAIT = 4) → CPU granted 4 cycles, DMA granted on the 5th, and the pattern repeats; wait_cnt never exceeds 4.
- Back-to-back reads: DMA reads 0xC000..0xC003 on consecutive cycles with CPU idle → dma_rvalid asserted on 4 consecutive cycles, data in order.
- Interleaved ownership: CPU read of 0xC020 granted, then DMA read granted the next cycle → cpu_rvalid then dma_rvalid on successive cycles, each carrying its own data; no cross-steering.
- WRAM_ARB_LOCK_EN: DMA sets dma_lock, writes 3 bytes with a 1-cycle req gap while cpu_req is held → cpu_gnt stays 0 until the cycle after dma_lock falls.
